decode_buffer: RTL and testbench

Parametrised decode stage that sits between fetch and issue. It decodes RV32I, Zicsr and the MUL/AMOSWAP.W subset at enqueue time, then stores the PC, instruction and decoded control bundle in a DEPTH-entry FIFO. It adds valid/ready handshakes on both sides, flush, an occupancy count, illegal-instruction flagging and a compile-time M-extension enable. Outputs come straight from FIFO storage, so they are registered.

---
 rtl/decode_buffer_pkg.sv | 128 ++++++++++++
 rtl/decode_buffer_decode_logic.sv | 159 +++++++++++++++
 rtl/decode_buffer.sv | 122 ++++++++++++
 tb/tb_decode_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_buffer_pkg.sv
// Shared instruction encodings and decoded-bundle layout for the decode stage.
// Holds match/mask constants, select-code localparams and the packed control bundle.
// Imported by decode_logic and decode_buffer; contains no logic state.
package decode_buffer_pkg;

  // Masks: full word, R-type (funct7+funct3+opcode), funct3+opcode, opcode only, AMO funct5
  localparam logic [31:0] MASK_ALL = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_R   = 32'hFE00_707F;
  localparam logic [31:0] MASK_F3  = 32'h0000_707F;
  localparam logic [31:0] MASK_OP  = 32'h0000_007F;
  localparam logic [31:0] MASK_AMO = 32'hF800_707F;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [31:0] LB  = 32'h0000_0003;
  localparam logic [31:0] LH  = 32'h0000_1003;
  localparam logic [31:0] LW  = 32'h0000_2003;
  localparam logic [31:0] LBU = 32'h0000_4003;
  localparam logic [31:0] LHU = 32'h0000_5003;

  localparam logic [31:0] SB = 32'h0000_0023;
  localparam logic [31:0] SH = 32'h0000_1023;
  localparam logic [31:0] SW = 32'h0000_2023;

  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063;
  localparam logic [31:0] BLT  = 32'h0000_4063;
  localparam logic [31:0] BGE  = 32'h0000_5063;
  localparam logic [31:0] BLTU = 32'h0000_6063;
  localparam logic [31:0] BGEU = 32'h0000_7063;

  localparam logic [31:0] JAL   = 32'h0000_006F;
  localparam logic [31:0] JALR  = 32'h0000_0067;
  localparam logic [31:0] LUI   = 32'h0000_0037;
  localparam logic [31:0] AUIPC = 32'h0000_0017;

  localparam logic [31:0] CSRRW  = 32'h0000_1073;
  localparam logic [31:0] CSRRS  = 32'h0000_2073;
  localparam logic [31:0] CSRRC  = 32'h0000_3073;
  localparam logic [31:0] CSRRWI = 32'h0000_5073;
  localparam logic [31:0] CSRRSI = 32'h0000_6073;
  localparam logic [31:0] CSRRCI = 32'h0000_7073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  localparam logic [31:0] MUL       = 32'h0200_0033;
  localparam logic [31:0] AMOSWAP_W = 32'h0800_202F;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLTU  = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_AMOSW = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;
  localparam logic [3:0] ALU_MUL   = 4'd12;

  localparam logic [1:0] WB_DMEM = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_NONE = 2'd3;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_SH = 3'd1;
  localparam logic [2:0] IMM_S  = 3'd2;
  localparam logic [2:0] IMM_B  = 3'd3;
  localparam logic [2:0] IMM_U  = 3'd4;
  localparam logic [2:0] IMM_J  = 3'd5;

  // Register-register ALU ops: exact pattern under MASK_R and the ALU code it selects
  localparam int N_ALU_R = 10;
  localparam logic [31:0] ALU_R_MATCH [N_ALU_R] = '{
    32'h0000_0033, 32'h4000_0033, 32'h0000_1033, 32'h0000_2033, 32'h0000_3033,
    32'h0000_4033, 32'h0000_5033, 32'h4000_5033, 32'h0000_6033, 32'h0000_7033};
  localparam logic [3:0] ALU_R_SEL [N_ALU_R] = '{
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

  // Register-immediate ALU ops; the shift forms need funct7 in the mask
  localparam int N_ALU_I = 9;
  localparam logic [31:0] ALU_I_MATCH [N_ALU_I] = '{
    32'h0000_0013, 32'h0000_2013, 32'h0000_3013, 32'h0000_4013, 32'h0000_6013,
    32'h0000_7013, 32'h0000_1013, 32'h0000_5013, 32'h4000_5013};
  localparam logic [31:0] ALU_I_MASK [N_ALU_I] = '{
    MASK_F3, MASK_F3, MASK_F3, MASK_F3, MASK_F3, MASK_F3, MASK_R, MASK_R, MASK_R};
  localparam logic [3:0] ALU_I_SEL [N_ALU_I] = '{
    ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA};
  localparam logic ALU_I_SHIFT [N_ALU_I] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL,
    CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_CSR, CLS_SYS, CLS_MUL, CLS_AMO, CLS_ILL
  } inst_class_t;

  // Decoded control bundle; stored as one packed vector per FIFO entry
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] uses_reg;
    logic       reg_wen;
    logic [1:0] wb_sel;
    logic [2:0] imm_sel;
    logic       alu_asel;
    logic       alu_bsel;
    logic [3:0] alu_sel;
    logic       dmem_we;
    logic       is_branch;
    logic       is_jump;
    logic       jump_early;
    logic       branch_unsigned;
    logic       illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  function automatic logic hit(input logic [31:0] instr, input logic [31:0] match,
                               input logic [31:0] mask);
    return (instr & mask) == match;
  endfunction

endpackage

// File: rtl/decode_buffer_decode_logic.sv
// Combinational RV32I/Zicsr/MUL/AMOSWAP.W decoder producing the stored control bundle.
// Latency: zero cycles, purely combinational.
// Backpressure: none; it is evaluated on whatever instruction is offered.
module decode_logic
  import decode_buffer_pkg::*;
#(
  parameter int EN_M   = 1,
  parameter int EN_CSR = 1
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic        r_hit;
  logic [3:0]  r_alu;
  logic        i_hit;
  logic [3:0]  i_alu;
  logic        i_shift;
  inst_class_t cls;

  // ALU table lookups; patterns are disjoint, first hit is kept
  always_comb begin
    r_hit   = 1'b0;
    r_alu   = ALU_ADD;
    i_hit   = 1'b0;
    i_alu   = ALU_ADD;
    i_shift = 1'b0;
    for (int k = 0; k < N_ALU_R; k++) begin
      if (!r_hit && hit(instr, ALU_R_MATCH[k], MASK_R)) begin
        r_hit = 1'b1;
        r_alu = ALU_R_SEL[k];
      end
    end
    for (int k = 0; k < N_ALU_I; k++) begin
      if (!i_hit && hit(instr, ALU_I_MATCH[k], ALU_I_MASK[k])) begin
        i_hit   = 1'b1;
        i_alu   = ALU_I_SEL[k];
        i_shift = ALU_I_SHIFT[k];
      end
    end
  end

  // Classify in listed priority order; NOP must win over ADDI
  always_comb begin
    cls = CLS_ILL;
    if (hit(instr, NOP, MASK_ALL))                                   cls = CLS_NOP;
    else if (r_hit)                                                  cls = CLS_ALU_R;
    else if (i_hit)                                                  cls = CLS_ALU_I;
    else if ((instr & MASK_F3) inside {LB, LH, LW, LBU, LHU})        cls = CLS_LOAD;
    else if ((instr & MASK_F3) inside {SB, SH, SW})                  cls = CLS_STORE;
    else if ((instr & MASK_F3) inside {BEQ, BNE, BLT, BGE, BLTU, BGEU}) cls = CLS_BRANCH;
    else if (hit(instr, JAL, MASK_OP))                               cls = CLS_JAL;
    else if (hit(instr, JALR, MASK_F3))                              cls = CLS_JALR;
    else if (hit(instr, LUI, MASK_OP))                               cls = CLS_LUI;
    else if (hit(instr, AUIPC, MASK_OP))                             cls = CLS_AUIPC;
    else if ((instr & MASK_F3) inside {CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI})
      cls = (EN_CSR != 0) ? CLS_CSR : CLS_ILL;
    else if (hit(instr, MRET, MASK_ALL) || hit(instr, ECALL, MASK_ALL))
      cls = (EN_CSR != 0) ? CLS_SYS : CLS_ILL;
    else if (hit(instr, MUL, MASK_R))
      cls = (EN_M != 0) ? CLS_MUL : CLS_ILL;
    else if (hit(instr, AMOSWAP_W, MASK_AMO))                        cls = CLS_AMO;
  end

  // Expand the class into the control bundle; illegal keeps every control at default
  always_comb begin
    dec          = '0;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    dec.funct3   = instr[14:12];
    dec.wb_sel   = WB_NONE;
    case (cls)
      CLS_NOP: ;
      CLS_ALU_R: begin
        dec.uses_reg = 2'b11;
        dec.reg_wen  = 1'b1;
        dec.wb_sel   = WB_ALU;
        dec.alu_sel  = r_alu;
      end
      CLS_ALU_I: begin
        dec.uses_reg = 2'b01;
        dec.reg_wen  = 1'b1;
        dec.wb_sel   = WB_ALU;
        dec.alu_bsel = 1'b1;
        dec.imm_sel  = i_shift ? IMM_SH : IMM_I;
        dec.alu_sel  = i_alu;
      end
      CLS_LOAD: begin
        dec.uses_reg = 2'b01;
        dec.reg_wen  = 1'b1;
        dec.wb_sel   = WB_DMEM;
        dec.alu_bsel = 1'b1;
        dec.imm_sel  = IMM_I;
      end
      CLS_STORE: begin
        dec.imm_sel  = IMM_S;
        dec.uses_reg = 2'b11;
        dec.alu_bsel = 1'b1;
        dec.dmem_we  = 1'b1;
      end
      CLS_BRANCH: begin
        dec.is_branch       = 1'b1;
        dec.imm_sel         = IMM_B;
        dec.uses_reg        = 2'b11;
        dec.alu_asel        = 1'b1;
        dec.alu_bsel        = 1'b1;
        dec.branch_unsigned = instr[13];
      end
      CLS_JAL: begin
        dec.jump_early = 1'b1;
        dec.is_jump    = 1'b1;
        dec.imm_sel    = IMM_J;
        dec.reg_wen    = 1'b1;
        dec.alu_asel   = 1'b1;
        dec.alu_bsel   = 1'b1;
        dec.wb_sel     = WB_NONE;
      end
      CLS_JALR: begin
        dec.is_jump  = 1'b1;
        dec.uses_reg = 2'b01;
        dec.reg_wen  = 1'b1;
        dec.alu_bsel = 1'b1;
        dec.wb_sel   = WB_NONE;
      end
      CLS_LUI, CLS_AUIPC: begin
        dec.imm_sel  = IMM_U;
        dec.reg_wen  = 1'b1;
        dec.wb_sel   = WB_ALU;
        dec.alu_asel = 1'b1;
        dec.alu_bsel = 1'b1;
        dec.alu_sel  = (cls == CLS_LUI) ? ALU_PASSB : ALU_ADD;
      end
      CLS_CSR: begin
        dec.uses_reg = 2'b01;
        dec.reg_wen  = 1'b1;
      end
      CLS_SYS: begin
        dec.uses_reg = 2'b01;
      end
      CLS_MUL: begin
        dec.uses_reg = 2'b11;
        dec.reg_wen  = 1'b1;
        dec.wb_sel   = WB_ALU;
        dec.alu_sel  = ALU_MUL;
      end
      CLS_AMO: begin
        dec.uses_reg = 2'b01;
        dec.reg_wen  = 1'b1;
        dec.wb_sel   = WB_DMEM;
        dec.alu_sel  = ALU_AMOSW;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_buffer.sv
// Decode-at-enqueue FIFO between fetch and issue; outputs come straight from storage.
// Latency: an instruction accepted at edge N into an empty buffer is presented after edge N.
// Backpressure: in_ready = count < DEPTH (no path from out_ready); head holds while out_ready low.
module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int EN_M   = 1,
  parameter int EN_CSR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [2:0]                 out_funct3,
  output logic [1:0]                 out_uses_reg,
  output logic                       out_reg_wen,
  output logic [1:0]                 out_wb_sel,
  output logic [2:0]                 out_imm_sel,
  output logic                       out_alu_asel,
  output logic                       out_alu_bsel,
  output logic [3:0]                 out_alu_sel,
  output logic                       out_dmem_we,
  output logic                       out_is_branch,
  output logic                       out_is_jump,
  output logic                       out_jump_early,
  output logic                       out_branch_unsigned,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    dec_t            dec;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  dec_t             in_dec;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             enq;
  logic             deq;

  decode_logic #(
    .EN_M   (EN_M),
    .EN_CSR (EN_CSR)
  ) u_decode (
    .instr (in_instr),
    .dec   (in_dec)
  );

  assign in_ready  = count < FULL_CNT;
  assign out_valid = count != '0;
  // flush suppresses both handshakes in its cycle
  assign enq = in_valid && in_ready && !flush;
  assign deq = out_valid && out_ready && !flush;

  // Pointer and occupancy state; rst beats flush beats normal traffic
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; payload needs no reset because out_valid masks it
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, dec: in_dec};
  end

  assign head                = mem[rd_ptr];
  assign out_pc              = head.pc;
  assign out_instr           = head.instr;
  assign out_rs1             = head.dec.rs1;
  assign out_rs2             = head.dec.rs2;
  assign out_rd              = head.dec.rd;
  assign out_funct3          = head.dec.funct3;
  assign out_uses_reg        = head.dec.uses_reg;
  assign out_reg_wen         = head.dec.reg_wen;
  assign out_wb_sel          = head.dec.wb_sel;
  assign out_imm_sel         = head.dec.imm_sel;
  assign out_alu_asel        = head.dec.alu_asel;
  assign out_alu_bsel        = head.dec.alu_bsel;
  assign out_alu_sel         = head.dec.alu_sel;
  assign out_dmem_we         = head.dec.dmem_we;
  assign out_is_branch       = head.dec.is_branch;
  assign out_is_jump         = head.dec.is_jump;
  assign out_jump_early      = head.dec.jump_early;
  assign out_branch_unsigned = head.dec.branch_unsigned;
  assign out_illegal         = head.dec.illegal;

endmodule

// File: tb/tb_decode_buffer.sv
// Randomised bench for decode_buffer against an opcode-level reference decoder and queue model.
// Two instances share stimulus: index 0 has M and CSR enabled, index 1 has both disabled.
// Inputs change #1 after the rising edge; outputs are sampled at that point too.
module tb_decode_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0] uses;
    logic       wen;
    logic [1:0] wb;
    logic [2:0] imm;
    logic       asel;
    logic       bsel;
    logic [3:0] alu;
    logic       dwe;
    logic       br;
    logic       jmp;
    logic       je;
    logic       bu;
    logic       ill;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush;
  logic [31:0] in_instr, in_pc;

  logic        in_ready_v [2];
  logic        out_valid_v [2];
  logic [31:0] pc_v [2];
  logic [31:0] instr_v [2];
  logic [4:0]  rs1_v [2];
  logic [4:0]  rs2_v [2];
  logic [4:0]  rd_v [2];
  logic [2:0]  f3_v [2];
  logic [1:0]  uses_v [2];
  logic        wen_v [2];
  logic [1:0]  wb_v [2];
  logic [2:0]  imm_v [2];
  logic        asel_v [2];
  logic        bsel_v [2];
  logic [3:0]  alu_v [2];
  logic        dwe_v [2];
  logic        br_v [2];
  logic        jmp_v [2];
  logic        je_v [2];
  logic        bu_v [2];
  logic        ill_v [2];
  logic [2:0]  count_v [2];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q_pc [$];
  logic [31:0] q_ins [$];

  always #5 clk = ~clk;

  decode_buffer #(.DEPTH(DEPTH), .PC_W(32), .EN_M(1), .EN_CSR(1)) u_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_pc(pc_v[0]), .out_instr(instr_v[0]),
    .out_rs1(rs1_v[0]), .out_rs2(rs2_v[0]), .out_rd(rd_v[0]), .out_funct3(f3_v[0]),
    .out_uses_reg(uses_v[0]), .out_reg_wen(wen_v[0]), .out_wb_sel(wb_v[0]),
    .out_imm_sel(imm_v[0]), .out_alu_asel(asel_v[0]), .out_alu_bsel(bsel_v[0]),
    .out_alu_sel(alu_v[0]), .out_dmem_we(dwe_v[0]), .out_is_branch(br_v[0]),
    .out_is_jump(jmp_v[0]), .out_jump_early(je_v[0]), .out_branch_unsigned(bu_v[0]),
    .out_illegal(ill_v[0]), .count(count_v[0]));

  decode_buffer #(.DEPTH(DEPTH), .PC_W(32), .EN_M(0), .EN_CSR(0)) u_min (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_pc(pc_v[1]), .out_instr(instr_v[1]),
    .out_rs1(rs1_v[1]), .out_rs2(rs2_v[1]), .out_rd(rd_v[1]), .out_funct3(f3_v[1]),
    .out_uses_reg(uses_v[1]), .out_reg_wen(wen_v[1]), .out_wb_sel(wb_v[1]),
    .out_imm_sel(imm_v[1]), .out_alu_asel(asel_v[1]), .out_alu_bsel(bsel_v[1]),
    .out_alu_sel(alu_v[1]), .out_dmem_we(dwe_v[1]), .out_is_branch(br_v[1]),
    .out_is_jump(jmp_v[1]), .out_jump_early(je_v[1]), .out_branch_unsigned(bu_v[1]),
    .out_illegal(ill_v[1]), .count(count_v[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? 4'd1 : 4'd0;
      3'd1:    return 4'd5;
      3'd2:    return 4'd9;
      3'd3:    return 4'd8;
      3'd4:    return 4'd4;
      3'd5:    return alt ? 4'd7 : 4'd6;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Reference decoder: opcode/funct3/funct7 view of the instruction set
  function automatic ctrl_t ref_decode(input logic [31:0] ins, input bit en_m, input bit en_csr);
    ctrl_t      r;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    f3 = ins[14:12];
    f7 = ins[31:25];
    r = '0;
    r.wb = 2'd3;
    ok = 1'b1;
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h01 && f3 == 3'd0) begin
          ok = en_m; r.uses = 2'b11; r.wen = 1; r.wb = 2'd1; r.alu = 4'd12;
        end else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          r.uses = 2'b11; r.wen = 1; r.wb = 2'd1; r.alu = alu_of(f3, f7[5]);
        end else ok = 0;
      end
      7'h13: begin
        if (ins == 32'h13) begin
          r.wb = 2'd3;
        end else if ((f3 == 3'd1 && f7 == 7'h00) ||
                     (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20))) begin
          r.uses = 2'b01; r.wen = 1; r.wb = 2'd1; r.bsel = 1; r.imm = 3'd1;
          r.alu = alu_of(f3, f7[5]);
        end else if (f3 != 3'd1 && f3 != 3'd5) begin
          r.uses = 2'b01; r.wen = 1; r.wb = 2'd1; r.bsel = 1; r.alu = alu_of(f3, 1'b0);
        end else ok = 0;
      end
      7'h03: begin
        if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
          r.uses = 2'b01; r.wen = 1; r.wb = 2'd0; r.bsel = 1;
        end else ok = 0;
      end
      7'h23: begin
        if (f3 <= 3'd2) begin
          r.imm = 3'd2; r.uses = 2'b11; r.bsel = 1; r.dwe = 1;
        end else ok = 0;
      end
      7'h63: begin
        if (f3 != 3'd2 && f3 != 3'd3) begin
          r.br = 1; r.imm = 3'd3; r.uses = 2'b11; r.asel = 1; r.bsel = 1;
          r.bu = (f3 == 3'd6 || f3 == 3'd7);
        end else ok = 0;
      end
      7'h6F: begin
        r.je = 1; r.jmp = 1; r.imm = 3'd5; r.wen = 1; r.asel = 1; r.bsel = 1;
      end
      7'h67: begin
        if (f3 == 3'd0) begin
          r.jmp = 1; r.uses = 2'b01; r.wen = 1; r.bsel = 1;
        end else ok = 0;
      end
      7'h37, 7'h17: begin
        r.imm = 3'd4; r.wen = 1; r.wb = 2'd1; r.asel = 1; r.bsel = 1;
        r.alu = (ins[6:0] == 7'h37) ? 4'd11 : 4'd0;
      end
      7'h73: begin
        if (!en_csr) ok = 0;
        else if (f3 != 3'd0 && f3 != 3'd4) begin
          r.uses = 2'b01; r.wen = 1;
        end else if (ins == 32'h0000_0073 || ins == 32'h3020_0073) begin
          r.uses = 2'b01;
        end else ok = 0;
      end
      7'h2F: begin
        if (f3 == 3'd2 && ins[31:27] == 5'b00001) begin
          r.uses = 2'b01; r.wen = 1; r.wb = 2'd0; r.alu = 4'd10;
        end else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      r = '0;
      r.wb = 2'd3;
      r.ill = 1;
    end
    return r;
  endfunction

  function automatic ctrl_t obs_ctrl(input int k);
    return {uses_v[k], wen_v[k], wb_v[k], imm_v[k], asel_v[k], bsel_v[k], alu_v[k],
            dwe_v[k], br_v[k], jmp_v[k], je_v[k], bu_v[k], ill_v[k]};
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("count%0d", k), 64'(count_v[k]), 64'(q_pc.size()));
      chk($sformatf("out_valid%0d", k), 64'(out_valid_v[k]), 64'(q_pc.size() != 0));
      chk($sformatf("in_ready%0d", k), 64'(in_ready_v[k]), 64'(q_pc.size() < DEPTH));
      if (q_pc.size() != 0) begin
        chk($sformatf("pc%0d", k), 64'(pc_v[k]), 64'(q_pc[0]));
        chk($sformatf("instr%0d", k), 64'(instr_v[k]), 64'(q_ins[0]));
        chk($sformatf("fields%0d", k), 64'({rs1_v[k], rs2_v[k], rd_v[k], f3_v[k]}),
            64'({q_ins[0][19:15], q_ins[0][24:20], q_ins[0][11:7], q_ins[0][14:12]}));
        chk($sformatf("ctrl%0d", k), 64'(obs_ctrl(k)),
            64'(ref_decode(q_ins[0], k == 0, k == 0)));
      end
    end
  endtask

  // One clock: predict the handshakes from the model, advance, update the model, compare
  task automatic step();
    bit acc, pop;
    acc = in_valid && (q_pc.size() < DEPTH) && !flush && !rst;
    pop = out_ready && (q_pc.size() > 0) && !flush && !rst;
    @(posedge clk);
    #1;
    if (rst || flush) begin
      q_pc.delete();
      q_ins.delete();
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      if (acc) begin
        q_pc.push_back(in_pc);
        q_ins.push_back(in_instr);
      end
    end
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] r;
    int          sel;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h2F};
    r = $urandom;
    sel = $urandom_range(0, 19);
    if (sel == 0) return 32'h0000_0013;
    if (sel == 1) return 32'h3020_0073;
    if (sel == 2) return 32'h0000_0073;
    if (sel == 3) return r;
    r[6:0] = ops[$urandom_range(0, 10)];
    case ($urandom_range(0, 4))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      3: r[31:27] = 5'b00001;
      default: ;
    endcase
    return r;
  endfunction

  task automatic offer(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = {$urandom_range(0, 16'hFFFF), 2'b00};
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    #1;
    step();
    step();
    rst = 1'b0;

    // addi x1,x0,5 at PC 0x100 with issue stalled
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid_v[0]), 64'd1);
    chk("t1_rd", 64'(rd_v[0]), 64'd1);
    chk("t1_wen", 64'(wen_v[0]), 64'd1);
    chk("t1_wb", 64'(wb_v[0]), 64'd1);
    chk("t1_bsel", 64'(bsel_v[0]), 64'd1);
    chk("t1_alu", 64'(alu_v[0]), 64'd0);
    chk("t1_imm", 64'(imm_v[0]), 64'd0);
    chk("t1_ill", 64'(ill_v[0]), 64'd0);
    chk("t1_count", 64'(count_v[0]), 64'd1);

    // Fill, then stream through a full buffer across pointer wrap
    for (int i = 0; i < 3; i++) offer(rand_instr());
    chk("t2_full_rdy", 64'(in_ready_v[0]), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) offer(rand_instr());
    in_valid = 1'b0;
    for (int i = 0; i < 8 && q_pc.size() > 0; i++) step();

    // MUL with M disabled vs enabled
    out_ready = 1'b0;
    offer(32'h0220_8033);
    in_valid = 1'b0;
    chk("t3_min_ill", 64'(ill_v[1]), 64'd1);
    chk("t3_min_wen", 64'(wen_v[1]), 64'd0);
    chk("t3_min_wb", 64'(wb_v[1]), 64'd3);
    chk("t3_full_alu", 64'(alu_v[0]), 64'd12);
    chk("t3_full_wen", 64'(wen_v[0]), 64'd1);
    chk("t3_full_ill", 64'(ill_v[0]), 64'd0);
    out_ready = 1'b1;
    step();

    // jal, bltu, sw
    out_ready = 1'b0;
    offer(32'h0000_006F);
    offer(32'h0020_E463);
    offer(32'h0011_2023);
    in_valid = 1'b0;
    chk("t4_jal_je", 64'(je_v[0]), 64'd1);
    chk("t4_jal_imm", 64'(imm_v[0]), 64'd5);
    out_ready = 1'b1;
    step();
    chk("t4_bltu_bu", 64'(bu_v[0]), 64'd1);
    chk("t4_bltu_imm", 64'(imm_v[0]), 64'd3);
    step();
    chk("t4_sw_we", 64'(dwe_v[0]), 64'd1);
    chk("t4_sw_wen", 64'(wen_v[0]), 64'd0);
    chk("t4_sw_imm", 64'(imm_v[0]), 64'd2);
    step();

    // Flush with simultaneous enqueue and dequeue
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer(rand_instr());
    flush = 1'b1; out_ready = 1'b1;
    offer(rand_instr());
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_count", 64'(count_v[0]), 64'd0);
    chk("t5_valid", 64'(out_valid_v[0]), 64'd0);

    // Long stall with a head entry, then reset mid-stream
    out_ready = 1'b0;
    offer(rand_instr());
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    offer(rand_instr());
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_count", 64'(count_v[0]), 64'd0);
    chk("t6_valid", 64'(out_valid_v[0]), 64'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
